// File: rtl/vga_pkg.sv
// Shared timing constants, text geometry and the fetch-pipeline stage record
// for the 640x480 / 80x30 text-mode pixel generator.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int CELL_W    = 8;
  localparam int CELL_H    = 16;

  localparam int H_W     = 10;
  localparam int V_W     = 10;
  localparam int VRAM_AW = 12;
  localparam int FONT_AW = 12;

  // Per-pixel context carried alongside the VRAM/font fetches.
  typedef struct packed {
    logic [2:0] hcell;
    logic [3:0] vrow;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       frame;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{
    hcell:  3'd0,
    vrow:   4'd0,
    active: 1'b0,
    hsync:  1'b1,
    vsync:  1'b1,
    frame:  1'b0
  };

  // row*80 + col built from two shifts so no multiplier is inferred.
  function automatic logic [VRAM_AW-1:0] cell_index(input logic [5:0] row,
                                                      input logic [6:0] col);
    logic [VRAM_AW-1:0] row_w;
    row_w = {6'd0, row};
    return (row_w << 6) + (row_w << 4) + {5'd0, col};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters and the stage-0 active, sync and frame flags derived
// directly from them.
module vga_timing
  import vga_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           frame
);

  logic [H_W-1:0] h_r;
  logic [V_W-1:0] v_r;

  // Horizontal counter wraps every line; vertical advances on that wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_r <= 10'd0;
      v_r <= 10'd0;
    end else if (h_r == 10'(H_TOTAL - 1)) begin
      h_r <= 10'd0;
      if (v_r == 10'(V_TOTAL - 1)) begin
        v_r <= 10'd0;
      end else begin
        v_r <= v_r + 10'd1;
      end
    end else begin
      h_r <= h_r + 10'd1;
    end
  end

  // Stage-0 flags, purely combinational from the counters.
  always_comb begin
    active = (h_r < 10'(H_ACTIVE)) && (v_r < 10'(V_ACTIVE));
    hsync  = !((h_r >= 10'(H_SYNC_START)) && (h_r <= 10'(H_SYNC_END)));
    vsync  = !((v_r >= 10'(V_SYNC_START)) && (v_r <= 10'(V_SYNC_END)));
    frame  = (h_r == 10'd0) && (v_r == 10'd0);
  end

  assign h_cnt = h_r;
  assign v_cnt = v_r;

endmodule

// File: rtl/vga_text_pixel_gen.sv
// 80x30 text-mode pixel generator: counters, VRAM/font fetch pipeline and
// registered pixel/palette/sync outputs, all with a fixed 3-cycle latency.
module vga_text_pixel_gen
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [15:0]        vram_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic [3:0]         pal_fg,
  output logic [3:0]         pal_bg,
  output logic               pix_fg,
  output logic               pix_active,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  logic [H_W-1:0] h_cnt_s;
  logic [V_W-1:0] v_cnt_s;
  logic           active_s;
  logic           hsync_s;
  logic           vsync_s;
  logic           frame_s;

  stage_t         s1_r;
  stage_t         s2_r;
  logic [7:0]     attr_s2_r;
  logic           glyph_bit_s;

  vga_timing u_timing (
    .clk    (clk),
    .rst_n  (rst_n),
    .h_cnt  (h_cnt_s),
    .v_cnt  (v_cnt_s),
    .active (active_s),
    .hsync  (hsync_s),
    .vsync  (vsync_s),
    .frame  (frame_s)
  );

  // Stage 0: text cell address; parked at 0 during blanking.
  always_comb begin
    if (active_s) begin
      vram_addr = cell_index(v_cnt_s[V_W-1:4], h_cnt_s[H_W-1:3]);
    end else begin
      vram_addr = 12'd0;
    end
  end

  // Stage 1: glyph row lookup from the returned character code.
  always_comb begin
    font_addr = {vram_data[7:0], s1_r.vrow};
  end

  // Stage 2: pick the glyph bit for this pixel column (MSB is leftmost).
  always_comb begin
    glyph_bit_s = font_data[3'(3'd7 - s2_r.hcell)];
  end

  // Pixel context pipeline tracking the two fetch cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r      <= STAGE_IDLE;
      s2_r      <= STAGE_IDLE;
      attr_s2_r <= 8'd0;
    end else begin
      s1_r      <= '{hcell:  h_cnt_s[2:0],
                     vrow:   v_cnt_s[3:0],
                     active: active_s,
                     hsync:  hsync_s,
                     vsync:  vsync_s,
                     frame:  frame_s};
      s2_r      <= s1_r;
      attr_s2_r <= vram_data[15:8];
    end
  end

  // Output registers: pixel data and timing leave together, glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_fg      <= 1'b0;
      pix_active  <= 1'b0;
      pal_fg      <= 4'd0;
      pal_bg      <= 4'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pix_fg      <= glyph_bit_s & s2_r.active;
      pix_active  <= s2_r.active;
      pal_fg      <= s2_r.active ? attr_s2_r[3:0] : 4'd0;
      pal_bg      <= s2_r.active ? attr_s2_r[7:4] : 4'd0;
      hsync       <= s2_r.hsync;
      vsync       <= s2_r.vsync;
      frame_start <= s2_r.frame;
    end
  end

endmodule
